// File: rtl/decode_queue.sv
// decode_queue: multi-lane decode stage feeding a circular buffer of decoded instructions
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int IN_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         in_valid,
  input  logic [32*IN_W-1:0]      in_instr,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [5:0]              out_ctrl,
  output logic [1:0]              out_aluop,
  output logic [1:0]              out_lwsw,
  output logic                    out_jump,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 44;
  function automatic logic [11:0] decode(input logic [6:0] op);
    case (op)
      7'b0110011: decode = 12'b100000_10_00_0_0;
      7'b0010011: decode = 12'b110000_10_00_0_0;
      7'b0000011: decode = 12'b110101_00_10_0_0;
      7'b0100011: decode = 12'b010010_00_01_0_0;
      7'b1100011: decode = 12'b001000_01_00_0_0;
      7'b0110111,
      7'b0010111: decode = 12'b110000_11_00_0_0;
      7'b1101111: decode = 12'b100000_00_00_1_0;
      7'b1100111: decode = 12'b110000_00_00_1_0;
      default:    decode = 12'b000000_00_00_0_1;
    endcase
  endfunction
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, slot;
  logic [CW-1:0] count_q, count_d, enq_n;
  logic          deq;
  logic [EW-1:0] head_e;
  assign in_ready  = count_q <= CW'(DEPTH - IN_W);
  assign out_valid = count_q != '0;
  assign count     = count_q;
  assign deq       = out_valid && out_ready;
  assign head_e    = out_valid ? mem_q[head_q] : '0;
  assign {out_instr, out_ctrl, out_aluop, out_lwsw, out_jump, out_illegal} = head_e;
  // compact valid lanes into consecutive slots from the tail, decoding on the way in
  always_comb begin
    mem_d = mem_q;
    enq_n = '0;
    slot  = tail_q;
    for (int k = 0; k < IN_W; k++) begin
      if (in_ready && in_valid[k]) begin
        mem_d[slot] = {in_instr[32*k +: 32], decode(in_instr[32*k +: 7])};
        slot        = slot + PW'(1);
        enq_n       = enq_n + CW'(1);
      end
    end
    head_d  = flush ? '0 : head_q + PW'(deq);
    tail_d  = flush ? '0 : slot;
    count_d = flush ? '0 : count_q + enq_n - CW'(deq);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // entry storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: vector table, corner sequences and random run against a queue model
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int IN_W = 2;
  localparam logic [11:0] D_Z    = 12'b000000_00_00_0_0;
  localparam logic [11:0] D_R    = 12'b100000_10_00_0_0;
  localparam logic [11:0] D_I    = 12'b110000_10_00_0_0;
  localparam logic [11:0] D_LW   = 12'b110101_00_10_0_0;
  localparam logic [11:0] D_SW   = 12'b010010_00_01_0_0;
  localparam logic [11:0] D_BR   = 12'b001000_01_00_0_0;
  localparam logic [11:0] D_U    = 12'b110000_11_00_0_0;
  localparam logic [11:0] D_JAL  = 12'b100000_00_00_1_0;
  localparam logic [11:0] D_JALR = 12'b110000_00_00_1_0;
  localparam logic [11:0] D_ILL  = 12'b000000_00_00_0_1;
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
  localparam logic [11:0] DECS [10] = '{D_R, D_I, D_LW, D_SW, D_BR, D_U, D_U, D_JAL, D_JALR, D_ILL};
  logic clk = 0;
  logic rst, flush, out_ready, out_valid, in_ready, out_jump, out_illegal;
  logic [1:0] in_valid, out_aluop, out_lwsw;
  logic [63:0] in_instr;
  logic [31:0] out_instr;
  logic [5:0] out_ctrl;
  logic [2:0] count;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mq[$];
  typedef struct {
    logic [1:0]  vld;
    logic [31:0] l1;
    logic [31:0] l0;
    logic        ordy;
    logic        fl;
    logic [48:0] exp;
  } vec_t;
  vec_t tbl[$];
  decode_queue #(.DEPTH(DEPTH), .IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_ctrl(out_ctrl), .out_aluop(out_aluop), .out_lwsw(out_lwsw), .out_jump(out_jump),
    .out_illegal(out_illegal), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [48:0] pk(int cnt, logic [31:0] oi, logic [11:0] dec);
    return {3'(cnt), cnt != 0, (DEPTH - cnt) >= IN_W, oi, dec};
  endfunction
  function automatic logic [48:0] act();
    return {count, out_valid, in_ready, out_instr, out_ctrl, out_aluop, out_lwsw, out_jump, out_illegal};
  endfunction
  function automatic logic [11:0] ref_dec(logic [6:0] op);
    logic [11:0] d;
    d = D_ILL;
    for (int i = 0; i < 9; i++) if (OPS[i] == op) d = DECS[i];
    return d;
  endfunction
  function automatic logic [48:0] exp_now();
    if (mq.size() == 0) return pk(0, 32'h0, D_Z);
    return pk(mq.size(), mq[0], ref_dec(mq[0][6:0]));
  endfunction
  function automatic vec_t mk(logic [1:0] vld, logic [31:0] l1, logic [31:0] l0, logic ordy, logic fl,
                              int cnt, logic [31:0] oi, logic [11:0] dec);
    vec_t v;
    v.vld = vld; v.l1 = l1; v.l0 = l0; v.ordy = ordy; v.fl = fl;
    v.exp = pk(cnt, oi, dec);
    return v;
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], OPS[$urandom_range(0, 9)]};
  endfunction
  task automatic chk(string nm, logic [48:0] a, logic [48:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic step(logic [1:0] vld, logic [63:0] ins, logic ordy, logic fl, string nm);
    logic rdy;
    in_valid = vld; in_instr = ins; out_ready = ordy; flush = fl;
    rdy = (DEPTH - mq.size()) >= IN_W;
    if (fl) mq.delete();
    else begin
      if (mq.size() != 0 && ordy) void'(mq.pop_front());
      if (rdy) for (int k = 0; k < IN_W; k++) if (vld[k]) mq.push_back(ins[32*k +: 32]);
    end
    @(posedge clk); #1;
    chk(nm, act(), exp_now());
  endtask
  initial begin
    rst = 1; flush = 0; out_ready = 0; in_valid = 2'b11; in_instr = {32'h003100B3, 32'h003100B3};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset%0d", i), act(), pk(0, 32'h0, D_Z));
    end
    rst = 0;
    tbl.push_back(mk(2'b11, 32'h0050A223, 32'h0000A283, 1, 0, 2, 32'h0000A283, D_LW));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h0050A223, D_SW));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0, D_Z));
    tbl.push_back(mk(2'b10, 32'h000000EF, 32'h12345678, 0, 0, 1, 32'h000000EF, D_JAL));
    tbl.push_back(mk(2'b01, 32'h000000EF, 32'h00000000, 1, 0, 1, 32'h00000000, D_ILL));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0, D_Z));
    tbl.push_back(mk(2'b11, 32'h003100B3, 32'h003100B3, 0, 0, 2, 32'h003100B3, D_R));
    tbl.push_back(mk(2'b11, 32'h003100B3, 32'h003100B3, 0, 0, 4, 32'h003100B3, D_R));
    tbl.push_back(mk(2'b11, 32'h00000013, 32'h00000013, 0, 0, 4, 32'h003100B3, D_R));
    tbl.push_back(mk(2'b11, 32'h00000013, 32'h00000013, 1, 0, 3, 32'h003100B3, D_R));
    tbl.push_back(mk(2'b11, 32'h00000013, 32'h00000013, 1, 0, 2, 32'h003100B3, D_R));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h003100B3, D_R));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0, D_Z));
    tbl.push_back(mk(2'b11, 32'h000002B7, 32'h000002B7, 0, 0, 2, 32'h000002B7, D_U));
    tbl.push_back(mk(2'b11, 32'h00008067, 32'h00000297, 1, 0, 3, 32'h000002B7, D_U));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 2, 32'h00000297, D_U));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 1, 32'h00008067, D_JALR));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0, D_Z));
    tbl.push_back(mk(2'b11, 32'h00100093, 32'h00208463, 0, 0, 2, 32'h00208463, D_BR));
    tbl.push_back(mk(2'b01, 32'h0, 32'h00000013, 0, 0, 3, 32'h00208463, D_BR));
    tbl.push_back(mk(2'b11, 32'h0000A283, 32'h0000A283, 1, 1, 0, 32'h0, D_Z));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0, D_Z));
    tbl.push_back(mk(2'b01, 32'h0, 32'h00000063, 0, 0, 1, 32'h00000063, D_BR));
    tbl.push_back(mk(2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0, D_Z));
    foreach (tbl[i]) begin
      in_valid = tbl[i].vld; in_instr = {tbl[i].l1, tbl[i].l0};
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), act(), tbl[i].exp);
    end
    mq.delete();
    for (int c = 0; c < 80; c++)
      step(($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3)), {rnd_instr(), rnd_instr()},
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $sformatf("rand%0d", c));
    for (int c = 0; c < DEPTH + 1; c++) step(2'b00, 64'h0, 1'b1, 1'b0, $sformatf("drain%0d", c));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised multi-lane decode stage with a decoded-instruction buffer, placed between fetch and rename/dispatch in the out-of-order core. Each cycle it accepts up to IN_W instructions. It decodes each one's opcode into the standard control bundle and stores the result in a circular queue of DEPTH entries. It delivers one decoded entry per cycle to dispatch under a valid/ready handshake. Compared with the single-instruction combinational controller, it adds lanes, buffering, flush, and decode of U/J-type and jump instructions.

## Interface
- DEPTH, 8: queue entries; power of two, DEPTH ≥ IN_W.
- IN_W, 2: enqueue lanes (1..4).
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  IN_W  per-lane valid; lane k occupies in_instr[32k+31:32k].
- in_instr  input  32*IN_W  raw instructions.
- in_ready  output  1  high when free slots ≥ IN_W.
- flush  input  1  discard all queued entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  dispatch accepts head.
- out_instr  output  32  head raw instruction.
- out_ctrl  output  6  control signals.
- out_aluop  output  2  ALU op class.
- out_lwsw  output  2  10 = load, 01 = store, else 00.
- out_jump  output  1  JAL/JALR.
- out_illegal  output  1  unrecognised opcode.
- count  output  $clog2(DEPTH)+1  occupied entries.

## Operation
- The decode table applies to instr[6:0]. Each row gives ctrl / aluop / lwsw / jump:
  - 0110011 R: 100000/10/00/0
  - 0010011 I: 110000/10/00/0
  - 0000011 load: 110101/00/10/0
  - 0100011 store: 010010/00/01/0
  - 1100011 branch: 001000/01/00/0
  - 0110111 LUI and 0010111 AUIPC: 110000/11/00/0
  - 1101111 JAL: 100000/00/00/1
  - 1100111 JALR: 110000/00/00/1
  - Any other opcode: all zero, illegal=1.
- Decode happens at enqueue. The queue stores {instr, ctrl, aluop, lwsw, jump, illegal}.
- Enqueue fires when in_ready is high. All lanes with in_valid=1 are written in ascending lane order to consecutive slots starting at the tail. Invalid lanes are skipped, so gaps are compacted. The tail advances by popcount(in_valid).
- When in_ready=0, in_valid is ignored and nothing is written.
- Dequeue fires when out_valid && out_ready. The head advances by 1.
- Head and tail pointers wrap modulo DEPTH.
- count_next = count + enq_n − deq, where enq_n is the popcount of in_valid when enqueue fires, else 0.
- When out_valid=0, all out_* data outputs are 0.
- Flush has priority. Any enqueue or dequeue in the same cycle is discarded. Head, tail and count all become 0 on the next edge.

## Timing
- Reset: on a rising edge with rst=1, head=tail=count=0, out_valid=0 and all out_* are 0. The queue RAM contents are don't-care.
- in_ready = (DEPTH − count ≥ IN_W). It is combinational from registered count only. A dequeue in the same cycle does not raise it, so there is no comb path from out_ready to in_ready.
- Latency: an instruction enqueued at edge N appears at the head with out_valid=1 after edge N when the queue was empty. There is no same-cycle bypass.
- out_valid = (count ≠ 0). Outputs are a registered-state read of the head slot.
- Simultaneous enqueue and dequeue are legal, including when count = DEPTH − IN_W.
- Full: count = DEPTH is reachable. in_ready stays 0 until count ≤ DEPTH − IN_W.
- Reset or flush mid-stream: entries accepted in that cycle are lost. out_valid=0 on the following cycle.

## Test plan
- Reset: assert rst for 2 cycles while in_valid=11 → count=0, out_valid=0, in_ready=1, all out_* are 0.
- Two-lane order: enqueue lane0=0x0000A283 (lw) and lane1=0x0050A223 (sw), out_ready=1.
  - Cycle+1: out_ctrl=110101, aluop=00, lwsw=10.
  - Cycle+2: out_ctrl=010010, lwsw=01.
  - Cycle+3: out_valid=0.
- Compaction and new opcodes: in_valid=10 with lane1=0x000000EF (JAL) → count=1, out_ctrl=100000, out_jump=1. Then enqueue 0x00000000 → out_illegal=1, out_ctrl=000000.
- Full and backpressure (DEPTH=4, IN_W=2), out_ready=0:
  - Enqueue pairs of 0x003100B3 → count 2, then 4.
  - Once count reaches 4: in_ready=0, further in_valid is ignored, count stays 4.
  - Raise out_ready for 2 cycles → count=2, in_ready=1.
- Wrap-around: run 20 cycles of continuous 2-in/1-out with random opcodes from the table, throttled by in_ready → the dequeued sequence matches the scoreboard exactly and pointers wrap without loss.
- Flush with enqueue: at count=3, assert flush together with in_valid=11 and out_ready=1 → next cycle count=0, out_valid=0. The dequeue in the flush cycle is not counted as accepted.
